// File: rtl/heapsort_sort_driver_pkg.sv
// Shared definitions for the heapsort sort driver and the priority queue it commands.
package heapsort_sort_driver_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 34;
  localparam int STAT_W = 36;

  // Command word opcodes, carried in cmd[CMD_OP_HI:CMD_OP_LO].
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  // Queue state code meaning "idle, will accept a command".
  localparam logic [2:0] QS_READY = 3'b110;

  // Command field offsets.
  localparam int CMD_OP_HI  = 33;
  localparam int CMD_OP_LO  = 32;
  localparam int CMD_ARG_HI = 31;
  localparam int CMD_ARG_LO = 0;

  // Status field offsets.
  localparam int ST_STATE_HI = 35;
  localparam int ST_STATE_LO = 33;
  localparam int ST_TOP_VLD  = 32;
  localparam int ST_TOP_HI   = 31;
  localparam int ST_TOP_LO   = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_PUSH = 3'd2,
    S_LATCH     = 3'd3,
    S_PRESENT   = 3'd4,
    S_WAIT_POP  = 3'd5
  } state_t;

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op, input logic [DATA_W-1:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/heapsort_sort_driver_if.sv
// Stream, queue command/status and flag signals of the sort driver.
interface heapsort_sort_driver_if;
  import heapsort_sort_driver_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [CMD_W-1:0]  cmd_o;
  logic [STAT_W-1:0] status_i;
  logic              busy;
  logic              ovf;

  // The driver itself.
  modport master (
    input  in_valid, in_data, in_last, out_ready, status_i,
    output in_ready, out_valid, out_data, out_last, cmd_o, busy, ovf
  );

  // Stream source/sink and the attached queue.
  modport slave (
    output in_valid, in_data, in_last, out_ready, status_i,
    input  in_ready, out_valid, out_data, out_last, cmd_o, busy, ovf
  );

endinterface

// File: rtl/heapsort_sort_driver.sv
// Sort driver: pushes a batch of words into the priority queue, then pops it back
// out minimum-first onto the output stream.
module heapsort_sort_driver
  import heapsort_sort_driver_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int CW    = 3
) (
  input  logic                   system1000,
  input  logic                   system1000_rstn,
  heapsort_sort_driver_if.master bus
);

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              gap_q, gap_d;      // set on the cycle after a command: status is still stale
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              ovf_q, ovf_d;

  logic qs_ready;
  logic top_valid;
  logic in_ready;
  logic accept;

  assign qs_ready  = (bus.status_i[ST_STATE_HI:ST_STATE_LO] == QS_READY);
  assign top_valid = bus.status_i[ST_TOP_VLD];
  assign in_ready  = (state_q == S_LOAD) && qs_ready && (count_q < CW'(DEPTH));
  assign accept    = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.cmd_o     = cmd_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ovf       = ovf_q;

  // State and output registers; reset abandons any batch in flight.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      cmd_q       <= mk_cmd(OP_NOP, '0);
      gap_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cmd_q       <= cmd_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic; a command is a one-cycle pulse, so cmd_d defaults to NOP.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cmd_d       = mk_cmd(OP_NOP, '0);
    gap_d       = gap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (qs_ready) state_d = S_LOAD;
      end

      S_LOAD: begin
        if (accept) begin
          cmd_d   = mk_cmd(OP_PUSH, bus.in_data);
          count_d = count_q + CW'(1);
          gap_d   = 1'b1;
          if (count_q == '0) ovf_d = 1'b0;
          if (bus.in_last) begin
            state_d = S_LATCH;
          end else if ((count_q + CW'(1)) == CW'(DEPTH)) begin
            // Queue full before in_last: close the batch here, keep the rest for later.
            ovf_d   = 1'b1;
            state_d = S_LATCH;
          end else begin
            state_d = S_WAIT_PUSH;
          end
        end
      end

      S_WAIT_PUSH: begin
        if (gap_q)         gap_d   = 1'b0;
        else if (qs_ready) state_d = S_LOAD;
      end

      S_LATCH: begin
        // A missing top with count>0 is a queue fault: we simply stay here.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (qs_ready && top_valid) begin
          out_data_d  = bus.status_i[ST_TOP_HI:ST_TOP_LO];
          out_valid_d = 1'b1;
          out_last_d  = (count_q == CW'(1));
          state_d     = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cmd_d       = mk_cmd(OP_POP, '0);
          count_d     = count_q - CW'(1);
          gap_d       = 1'b1;
          state_d     = S_WAIT_POP;
        end
      end

      S_WAIT_POP: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (qs_ready) begin
          state_d = (count_q != '0) ? S_LATCH : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_heapsort_sort_driver.sv
// Bench: sort driver paired with a behavioural priority queue, checked against a
// batch/sort reference model.
module tb_heapsort_sort_driver;
  import heapsort_sort_driver_pkg::*;

  localparam int DEPTH  = 5;
  localparam int CW     = 3;
  localparam int BUDGET = 3000;

  typedef struct {
    logic [31:0] d;
    bit          last;
    bit          ovf;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  heapsort_sort_driver_if bus();

  heapsort_sort_driver #(.DEPTH(DEPTH), .CW(CW)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- attached priority queue (behavioural) ----------------
  logic [31:0] pq_mem [DEPTH];
  int          pq_n;
  logic [2:0]  pq_state;
  int          pq_dly;
  int          pq_mi;

  always_comb begin
    pq_mi = 0;
    for (int i = 1; i < DEPTH; i++)
      if (i < pq_n && pq_mem[i] < pq_mem[pq_mi]) pq_mi = i;
  end

  assign bus.status_i = {pq_state, (pq_n > 0), (pq_n > 0) ? pq_mem[pq_mi] : 32'd0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pq_n     <= 0;
      pq_state <= QS_READY;
      pq_dly   <= 0;
    end else if (pq_state != QS_READY) begin
      if (pq_dly == 0) pq_state <= QS_READY;
      else             pq_dly   <= pq_dly - 1;
    end else begin
      case (bus.cmd_o[CMD_OP_HI:CMD_OP_LO])
        OP_PUSH: begin
          if (pq_n < DEPTH) begin
            pq_mem[pq_n] <= bus.cmd_o[CMD_ARG_HI:CMD_ARG_LO];
            pq_n         <= pq_n + 1;
          end
          pq_state <= 3'b001;
          pq_dly   <= int'($urandom_range(2));
        end
        OP_POP: begin
          if (pq_n > 0) begin
            pq_mem[pq_mi] <= pq_mem[pq_n-1];
            pq_n          <= pq_n - 1;
          end
          pq_state <= 3'b001;
          pq_dly   <= int'($urandom_range(2));
        end
        default: ;
      endcase
    end
  end

  // ---------------- command monitor ----------------
  int          push_cnt = 0;
  int          pop_cnt  = 0;
  logic [31:0] push_log[$];

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (bus.cmd_o[CMD_OP_HI:CMD_OP_LO] == OP_PUSH) begin
        push_cnt++;
        push_log.push_back(bus.cmd_o[CMD_ARG_HI:CMD_ARG_LO]);
        chk("in_ready_in_push_gap", bus.in_ready, 0);
      end
      if (bus.cmd_o[CMD_OP_HI:CMD_OP_LO] == OP_POP) pop_cnt++;
    end
  end

  // ---------------- stimulus and reference model ----------------
  logic [31:0] stim_w[$];
  bit          stim_l[$];
  exp_t        exp_q[$];

  // Split the stream into batches (closed by in_last or by reaching DEPTH) and sort each.
  task automatic build_expected();
    logic [31:0] cur[$];
    exp_t        e;
    exp_q.delete();
    for (int i = 0; i < stim_w.size(); i++) begin
      cur.push_back(stim_w[i]);
      if (stim_l[i] || cur.size() == DEPTH) begin
        cur.sort();
        for (int j = 0; j < cur.size(); j++) begin
          e.d    = cur[j];
          e.last = (j == cur.size() - 1);
          e.ovf  = !stim_l[i];
          exp_q.push_back(e);
        end
        cur.delete();
      end
    end
  endtask

  task automatic drive_inputs(input int vpct);
    int idx = 0;
    int cyc = 0;
    bit acc = 0;
    while (idx < stim_w.size() && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        bus.in_valid = 1'b0;
        acc = 0;
      end
      if (!bus.in_valid && int'($urandom_range(99)) < vpct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim_w[idx];
        bus.in_last  = stim_l[idx];
      end
      if (bus.in_valid && bus.in_ready) begin
        $display("IN   data=%08h last=%0d", bus.in_data, bus.in_last);
        idx++;
        acc = 1;
      end
    end
    if (idx < stim_w.size()) chk("in_timeout", 64'(idx), 64'(stim_w.size()));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic consume(input int rpct, input bit hold);
    int          n_exp = exp_q.size();
    int          got = 0;
    int          cyc = 0;
    int          hold_left = hold ? 10 : 0;
    int          pop_at_hold = 0;
    bit          pend = 0;
    logic [31:0] prev = '0;
    exp_t        e;
    while (got < n_exp && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (pend) chk("out_stable", {31'd0, bus.out_valid, bus.out_data}, {31'd0, 1'b1, prev});
      if (bus.out_valid && hold_left > 0) begin
        if (hold_left == 10) pop_at_hold = pop_cnt;
        bus.out_ready = 1'b0;
        hold_left--;
        if (hold_left == 0) chk("no_pop_while_held", 64'(pop_cnt), 64'(pop_at_hold));
      end else begin
        bus.out_ready = (int'($urandom_range(99)) < rpct);
      end
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        $display("OUT  data=%08h last=%0d ovf=%0d (exp %08h/%0d/%0d)",
                 bus.out_data, bus.out_last, bus.ovf, e.d, e.last, e.ovf);
        chk("out_data", 64'(bus.out_data), 64'(e.d));
        chk("out_last", 64'(bus.out_last), 64'(e.last));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        got++;
        pend = 0;
      end else if (bus.out_valid) begin
        pend = 1;
        prev = bus.out_data;
      end else begin
        pend = 0;
      end
    end
    if (got < n_exp) chk("out_timeout", 64'(got), 64'(n_exp));
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_stream(input int vpct, input int rpct, input bit hold);
    int push0 = push_cnt;
    int pop0  = pop_cnt;
    int cyc   = 0;
    build_expected();
    push_log.delete();
    fork
      drive_inputs(vpct);
      consume(rpct, hold);
    join
    while (bus.busy && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_falls", 64'(bus.busy), 0);
    chk("push_count", 64'(push_cnt - push0), 64'(stim_w.size()));
    chk("pop_count", 64'(pop_cnt - pop0), 64'(stim_w.size()));
    for (int i = 0; i < stim_w.size() && i < push_log.size(); i++)
      chk("push_operand", 64'(push_log[i]), 64'(stim_w[i]));
  endtask

  initial begin
    int cyc;
    int nb;
    int len;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_out_last", 64'(bus.out_last), 0);
    chk("rst_cmd", 64'(bus.cmd_o), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_ovf", 64'(bus.ovf), 0);
    rstn = 1'b1;

    // Basic batch, always-ready sink.
    stim_w = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd5};
    stim_l = '{0, 0, 0, 0, 1};
    run_stream(100, 100, 0);

    // Single word batch.
    stim_w = '{32'd42};
    stim_l = '{1};
    run_stream(100, 100, 0);

    // Six words overflow a five-deep queue; the sixth starts a new batch.
    stim_w = '{32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    stim_l = '{0, 0, 0, 0, 0, 1};
    run_stream(100, 100, 0);

    // Sink stalls for ten cycles on the first output.
    stim_w = '{32'd11, 32'd2, 32'd8};
    stim_l = '{0, 0, 1};
    run_stream(100, 100, 1);

    // Duplicates and full-width extremes.
    stim_w = '{32'd4, 32'd4, 32'hFFFF_FFFF, 32'd0};
    stim_l = '{0, 0, 0, 1};
    run_stream(100, 100, 0);

    // Randomised streams of several batches, with random valid/ready duty cycles.
    for (int r = 0; r < 8; r++) begin
      stim_w.delete();
      stim_l.delete();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        len = int'($urandom_range(1, 7));
        for (int k = 0; k < len; k++) begin
          stim_w.push_back(($urandom_range(1) != 0) ? 32'($urandom_range(7)) : $urandom);
          stim_l.push_back(k == len - 1);
        end
      end
      run_stream(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0);
    end

    // Asynchronous reset while an output is being presented.
    stim_w = '{32'd30, 32'd10, 32'd20};
    stim_l = '{0, 0, 1};
    drive_inputs(100);
    cyc = 0;
    while (!bus.out_valid && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_present", 64'(bus.out_valid), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 0);
    chk("arst_out_data", 64'(bus.out_data), 0);
    chk("arst_out_last", 64'(bus.out_last), 0);
    chk("arst_cmd", 64'(bus.cmd_o), 0);
    chk("arst_busy", 64'(bus.busy), 0);
    chk("arst_in_ready", 64'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("idle_after_release", 64'(bus.busy), 0);
    @(negedge clk);
    chk("load_after_idle", 64'(bus.busy), 1);

    // The driver recovers cleanly after the reset.
    stim_w = '{32'd3, 32'd1, 32'd2};
    stim_l = '{0, 0, 1};
    run_stream(100, 70, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/heapsort_sort_driver.md
Name: heapsort_sort_driver

Overview:
- Initiator side of the heap priority-queue command/status interface: accepts a batch of unsigned 32-bit words on a valid/ready input stream and pushes each one into the queue.
- Then repeatedly reads the queue top and pops it, emitting the batch in queue order (minimum first) on a valid/ready output stream.
- Sits between the system stream fabric and the priority-queue Moore machine. It drives the queue's 34-bit command word and consumes its 36-bit status word.

Parameters:
- DEPTH, 5, queue capacity in elements; must match the attached queue.
- CW, 3, counter width; must be at least clog2(DEPTH+1).

Ports:
- system1000  input  1  clock, rising edge.
- system1000_rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  driver accepts in_data this cycle.
- in_data  input  32  unsorted word.
- in_last  input  1  final word of batch.
- out_valid  output  1  sorted word valid.
- out_ready  input  1  sink accepts out_data.
- out_data  output  32  sorted word.
- out_last  output  1  final word of batch.
- cmd_o  output  34  queue command: [33:32] op (00 NOP, 01 PUSH, 10 POP), [31:0] operand.
- status_i  input  36  queue status: [35:33] state, [32] top valid, [31:0] top value.
- busy  output  1  batch in progress.
- ovf  output  1  sticky: batch truncated at DEPTH; cleared on first accept of next batch.

Behaviour:
- Reset (async, any state): FSM to IDLE, count=0, cmd_o=34'd0 (NOP), in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, ovf=0.
- qs_ready is defined as status_i[35:33]==3'b110 (queue idle, accepts a command).
- cmd_o is registered. PUSH/POP is held for exactly one cycle, then it returns to NOP.
- States:
  - IDLE: in_ready=0. Go to LOAD next cycle when qs_ready. busy=0 only in IDLE.
  - LOAD: in_ready = qs_ready and count<DEPTH. On accept (in_valid&in_ready):
    - cmd_o <= {01,in_data}, count+1.
    - If count was 0: clear ovf.
    - Go to WAIT_PUSH, or to LATCH if in_last.
    - If in_last=0 and the new count==DEPTH: set ovf and go to LATCH (truncation; the next in_valid word starts a new batch later).
  - WAIT_PUSH: first cycle ignores status_i (queue latency gap). Afterward, return to LOAD when qs_ready.
  - LATCH: first cycle ignores status_i. Afterward, when qs_ready and status_i[32]:
    - out_data <= status_i[31:0], out_valid<=1, out_last <= (count==1).
    - Go to PRESENT.
  - PRESENT: out_valid and out_data stable until out_ready. On handshake:
    - out_valid<=0, cmd_o <= {10,32'd0}, count-1.
    - Go to WAIT_POP.
  - WAIT_POP: first cycle ignores status_i. Afterward, when qs_ready, go to LATCH if count!=0, else IDLE.
- Latency: a push occupies at least 2 cycles per word. In steady state the first output is valid 2 cycles after the final push command.
- in_ready is never high outside LOAD. It is also low while the cycle-after-push gap is active.
- Equal values are emitted in whatever order the queue yields; the driver does not reorder.
- status_i[32]=0 while in LATCH with count>0 is a queue fault: remain in LATCH, out_valid stays 0.
- A zero-length batch is impossible; the first accepted word always starts a batch.
- Reset mid-batch abandons the batch; the queue must be reset by the same reset.

Decomposition:
- Shared package holds:
  - OP_NOP=2'b00, OP_PUSH=2'b01, OP_POP=2'b10.
  - QS_READY=3'b110.
  - Command/status field offsets.
  - FSM state encoding (IDLE, LOAD, WAIT_PUSH, LATCH, PRESENT, WAIT_POP).
- No sub-module. The bench instantiates this driver with the priority-queue block as the DUT pair.

Test Plan:
- Batch 7,3,9,1,5 with in_last on 5 and out_ready=1 -> output 1,3,5,7,9, out_last only with 9, ovf=0, then busy falls.
- Batch 42 (single word, in_last) -> one output 42 with out_last=1. cmd_o shows exactly one PUSH {01,42} and one POP.
- Six words 6,5,4,3,2,1, last on 1 -> 2,3,4,5,6 emitted, ovf=1. Word 1 is held (in_ready=0) and starts the next batch; ovf clears on its accept.
- out_ready held low 10 cycles in PRESENT -> out_valid and out_data stable, no POP issued, count unchanged.
- Duplicates 4,4,0xFFFFFFFF,0 -> 0,4,4,0xFFFFFFFF (unsigned ordering, full-width values).
- system1000_rstn asserted in PRESENT -> all outputs 0 within the same cycle (async), cmd_o=NOP, FSM back in IDLE after release.
